// File: rtl/mul_seq_ctrl_pkg.sv
// Shared definitions for the shift-add multiply sequencer: state encoding
// and the default operand width.
package mul_seq_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_seq_ctrl_add_n.sv
// WIDTH-bit ripple adder with carry-out, assembled from half/full adder cells.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic co
);
  assign s  = x ^ y;
  assign co = x & y;
endmodule

module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module add_n #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  // c[i] is the carry into bit i; bit 0 has no carry-in.
  logic [WIDTH:1] c;

  half_adder u_ha0 (
    .x (a[0]),
    .y (b[0]),
    .s (sum[0]),
    .co(c[1])
  );

  for (genvar i = 1; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .x (a[i]),
      .y (b[i]),
      .ci(c[i]),
      .s (sum[i]),
      .co(c[i+1])
    );
  end

  assign cout = c[WIDTH];
endmodule

// File: rtl/mul_seq_ctrl.sv
// Unsigned shift-add multiplier sequencer: one add/shift step per cycle,
// fixed WIDTH-cycle latency, back-to-back starts accepted from DONE.
module mul_seq_ctrl
  import mul_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [1:0]           dbg_state
);

  // Handshake: start is accepted on any edge where the block is not busy
  // (IDLE or DONE); busy stays high for exactly WIDTH cycles afterwards and
  // done pulses one cycle with product valid; start during busy is ignored.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t               state, state_next;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH-1:0]   acc;
  logic [CW-1:0]        cnt;
  logic                 accept;
  logic                 last_step;
  logic [WIDTH-1:0]     sum;
  logic                 cout;
  logic [WIDTH-1:0]     hi_sel;
  logic                 carry_sel;
  logic [2*WIDTH-1:0]   acc_step;

  add_n #(.WIDTH(WIDTH)) u_add (
    .a   (acc[2*WIDTH-1:WIDTH]),
    .b   (mcand),
    .sum (sum),
    .cout(cout)
  );

  assign accept    = start && (state != RUN);
  assign last_step = (cnt == CW'(WIDTH - 1));

  // The carry never needs its own register: it is shifted into the top of
  // the accumulator in the same step that produced it.
  always_comb begin
    hi_sel    = acc[2*WIDTH-1:WIDTH];
    carry_sel = 1'b0;
    if (acc[0]) begin
      hi_sel    = sum;
      carry_sel = cout;
    end
    acc_step = {carry_sel, hi_sel, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_step) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand <= a;
      acc   <= {{WIDTH{1'b0}}, b};
      cnt   <= '0;
    end else if (state == RUN) begin
      acc <= acc_step;
      cnt <= cnt + CW'(1);
      if (last_step) product <= acc_step;
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: doc/mul_seq_ctrl.md
MUL_SEQ_CTRL -- requirements
Module: mul_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits; legal range 2..16.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin a multiply; sampled each rising edge.
REQ-005 Port: a  input  WIDTH  multiplicand, unsigned; sampled only on an accepted start.
REQ-006 Port: b  input  WIDTH  multiplier, unsigned; sampled only on an accepted start.
REQ-007 Port: busy  output  1  high while a multiply is in progress.
REQ-008 Port: done  output  1  one-cycle pulse marking product valid.
REQ-009 Port: product  output  2*WIDTH  unsigned result a*b.

Function
REQ-010 The block SHALL be a shift-add sequencer with three states: IDLE, RUN, DONE.
REQ-011 Start SHALL be accepted only in IDLE or DONE; start in RUN SHALL be ignored, with no effect on state, operands or count.
REQ-012 On an accepted start at edge E0, the block SHALL:
- latch a into the multiplicand register and b into the low half of the accumulator;
- clear the high half and the carry;
- clear the step counter;
- enter RUN with busy=1.
REQ-013 Each RUN edge SHALL:
- if accumulator bit 0 is 1, add the multiplicand into the high half, capturing the carry-out;
- then shift {carry, high, low} right by one bit;
- increment the counter.
REQ-014 The adder SHALL be WIDTH bits wide plus carry-out; no intermediate bit is ever lost.
REQ-015 After exactly WIDTH RUN steps, at edge E0+WIDTH, the block SHALL:
- enter DONE;
- set busy=0, done=1;
- load product with the full 2*WIDTH accumulator.
REQ-016 done SHALL be high for exactly one cycle. DONE SHALL fall to IDLE on the next edge unless start is accepted on that edge.
REQ-017 product SHALL hold its value until the DONE edge of the next completed multiply; it SHALL NOT change during RUN.
REQ-018 Start accepted in DONE SHALL begin a new multiply on that same edge: back-to-back throughput of one result per WIDTH+1 cycles.
REQ-019 Latency SHALL be fixed at WIDTH edges from start acceptance to done, independent of operand values; no early termination.
REQ-020 busy SHALL equal (state==RUN); done SHALL equal (state==DONE). Both SHALL be registered-state decodes with no combinational path from start.

Reset
REQ-021 rst high at a rising edge SHALL force state=IDLE and clear busy, done, product, accumulator, multiplicand, carry and counter to 0.
REQ-022 rst SHALL take priority over start on the same edge.
REQ-023 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow.

Structure
REQ-024 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-025 The adder SHALL be one sub-module, add_n: a WIDTH-bit ripple adder with carry-out built from the codebase's half/full adder cells, instantiated once.
REQ-026 The counter SHALL be sized to hold WIDTH-1, i.e. clog2(WIDTH) bits.

Verification
REQ-027 WIDTH=8; rst, then start with a=13, b=11 -> busy for 8 cycles, done pulse 8 edges after the start edge, product=0x008F.
REQ-028 a=255, b=255 -> product=0xFE01 (carry path exercised); a=0, b=200 -> product=0x0000 with the same 8-cycle latency.
REQ-029 start held high through RUN with changing a/b -> result reflects the operands latched at acceptance only; no restart.
REQ-030 start high in the DONE cycle with a=3, b=5 -> new RUN begins immediately, next done 9 cycles after the previous done, product=0x000F.
REQ-031 rst asserted at RUN step 4 -> next cycle state IDLE, product=0, no done pulse; a subsequent start with a=7, b=9 yields 0x003F.
REQ-032 rst and start high on the same edge -> state IDLE, busy=0.
